// File: rtl/mmio_if_pio_pkg.sv
// ============================================================================
// Module  : mmio_if_pio_pkg
// Brief   : Shared register offsets, status bit position and pulse FSM states
//           for the MMIO output PIO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_if_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  localparam int BUSY_BIT = 31;

  typedef enum logic [0:0] {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_if_pio_pulse_timer.sv
// ============================================================================
// Module  : mmio_if_pio_pulse_timer
// Brief   : Retriggerable down-counter that flags the last cycle of a pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_if_pio_pulse_timer
  import mmio_if_pio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trigger,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 expire,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  pulse_state_e         r_state;
  pulse_state_e         w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_load;

  // A zero length still yields a single-cycle pulse.
  assign w_load = (len == '0) ? C_CNT_ONE : len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PS_IDLE: begin
        if (trigger) begin
          w_state_nxt = PS_ACTIVE;
          w_cnt_nxt   = w_load;
        end
      end
      PS_ACTIVE: begin
        // A retrigger reloads rather than extends, even on the final cycle.
        if (trigger) begin
          w_cnt_nxt = w_load;
        end else if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = PS_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = PS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy   = (r_state == PS_ACTIVE);
    expire = (r_state == PS_ACTIVE) && !trigger && (r_cnt == C_CNT_ONE);
  end

endmodule

`default_nettype wire

// File: rtl/mmio_if_pio_out.sv
// ============================================================================
// Module  : mmio_if_pio_out
// Brief   : MMIO output PIO with atomic set/clear and hardware-timed pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_if_pio_out
  import mmio_if_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CNT_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] w_mask_nxt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [31:0]           r_rdata;
  logic [31:0]           w_rdata_nxt;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_wr;
  logic                  w_trigger;
  logic                  w_expire;
  logic                  w_busy;
  logic                  w_unused_wd;

  assign w_wd        = writedata[DATA_WIDTH-1:0];
  assign w_wr        = chipselect && !write_n;
  assign w_trigger   = w_wr && (address == ADDR_PULSE) && (w_wd != '0);
  assign w_unused_wd = &{1'b0, writedata};

  mmio_if_pio_pulse_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (w_trigger),
    .len     (r_len),
    .expire  (w_expire),
    .busy    (w_busy)
  );

  // CPU write is applied first; expiry then strips the masked bits.
  always_comb begin
    w_data_nxt = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:     w_data_nxt = w_wd;
        ADDR_PULSE:    w_data_nxt = r_data | w_wd;
        ADDR_OUTSET:   w_data_nxt = r_data | w_wd;
        ADDR_OUTCLEAR: w_data_nxt = r_data & ~w_wd;
        default:       w_data_nxt = r_data;
      endcase
    end
    if (w_expire) begin
      w_data_nxt = w_data_nxt & ~r_mask;
    end
  end

  always_comb begin
    w_mask_nxt = r_mask;
    if (w_trigger) begin
      w_mask_nxt = r_mask | w_wd;
    end
    if (w_expire) begin
      w_mask_nxt = '0;
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: w_rdata_nxt[DATA_WIDTH-1:0] = r_data;
      ADDR_PULSE: begin
        w_rdata_nxt[DATA_WIDTH-1:0] = r_mask;
        w_rdata_nxt[BUSY_BIT]       = w_busy;
      end
      ADDR_PULSE_LEN: w_rdata_nxt[CNT_WIDTH-1:0] = r_len;
      default:        w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= RESET_VALUE;
      r_mask  <= '0;
      r_len   <= '0;
      r_rdata <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_wr && (address == ADDR_PULSE_LEN)) begin
        r_len <= writedata[CNT_WIDTH-1:0];
      end
    end
  end

  assign out_port = r_data;
  assign readdata = r_rdata;

endmodule

`default_nettype wire
